gc_conf_sequencer: RTL
======================

Name: gc_conf_sequencer

Overview:
- Configuration front-end of the global controller: reads a packed configuration word stream and delivers it over the shared conf_bus/sel/output_selector bus to the GC sub-blocks (reinitializer, counters, ...).
- Handles one target at a time. For each target it waits for that target's conf_ack before moving to the next.
- Reports completion or a classified error to the host side.

Parameters:
- DIMENSION, 3, iteration-space dimensions; output_selector width.
- SELECT_WIDTH, 3, sub-block select id width.
- ITERATION_VARIABLE_WIDTH, 16, conf_bus/stream word width; must be >= SELECT_WIDTH+DIMENSION+1.
- ACK_TIMEOUT, 15, max cycles spent in WAIT_ACK.

Ports:
- conf_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a configuration run.
- src_valid  in  1  stream word valid.
- src_data  in  ITERATION_VARIABLE_WIDTH  stream word.
- src_ready  out  1  stream word accepted when src_valid&src_ready at posedge.
- conf_ack_bus  in  2**SELECT_WIDTH  conf_ack of each sub-block, indexed by select id.
- conf_bus  out  ITERATION_VARIABLE_WIDTH  configuration word to targets.
- sel  out  SELECT_WIDTH  target select id.
- output_selector  out  DIMENSION  thermometer mask of registers to load in the target.
- busy  out  1  run in progress.
- conf_done  out  1  run completed successfully; sticky.
- conf_error  out  1  run aborted; sticky.
- err_code  out  2  error cause: 1=bad header, 2=target already acked, 3=ack timeout.

Behaviour:
- Reset values (reset=0, asynchronous): state IDLE, sel=all-ones (SEL_IDLE), conf_bus=0, output_selector=0, src_ready=0, busy=0, conf_done=0, conf_error=0, err_code=0, all counters 0.
- SEL_IDLE = all-ones is reserved; no sub-block uses it. sel equals SEL_IDLE in every cycle in which no word is being delivered.
- Stream format, header word:
  - [SELECT_WIDTH-1:0] = target id
  - [SELECT_WIDTH+DIMENSION-1:SELECT_WIDTH] = mask
  - [ITERATION_VARIABLE_WIDTH-1] = last flag
  - followed by N payload words, N = popcount(mask).
- State IDLE:
  - On start go to HDR.
  - Clear conf_done, conf_error and err_code; set busy.
  - start is ignored in every state other than IDLE, DONE and ERR.
- State HDR:
  - src_ready=1.
  - On an accepted header, check in order:
    - target==SEL_IDLE, mask==0, or mask not of the form 0..01..1 -> ERR, err_code=1.
    - conf_ack_bus[target]==1 -> ERR, err_code=2.
    - Otherwise latch target, mask, last flag and remaining=N, then go to LOAD.
- State LOAD:
  - src_ready=1.
  - Registered outputs: in the cycle after a payload word is accepted, drive conf_bus=word, sel=target, output_selector=mask for exactly one cycle; otherwise sel=SEL_IDLE.
  - The target therefore samples exactly one word per accepted beat.
  - Gaps in src_valid insert SEL_IDLE cycles.
  - When the N-th word is accepted, go to WAIT_ACK. src_ready drops on the following cycle.
- State WAIT_ACK:
  - src_ready=0; the final word is on the bus during the first WAIT_ACK cycle.
  - From the second WAIT_ACK cycle sample conf_ack_bus[target]:
    - 1 and last flag set -> DONE.
    - 1 and last flag clear -> HDR.
  - The timeout counter counts WAIT_ACK cycles; reaching ACK_TIMEOUT without ack -> ERR, err_code=3.
- State DONE: conf_done=1, busy=0; start -> HDR with flags cleared.
- State ERR:
  - conf_error=1, busy=0, sel=SEL_IDLE.
  - Remaining stream words are not consumed.
  - start -> HDR with flags cleared. The host must flush the stream and reset the targets first.
- Reset mid-run: immediate return to reset values. A partially loaded target keeps its own state.
- At most one of conf_done/conf_error is set. busy=1 in HDR, LOAD and WAIT_ACK only.

Test Plan:
- Single target: start; header {last=1, mask=3'b111, id=6}; words 10,20,30 back-to-back; target model acks on 3rd sample -> sel=6 for exactly 3 cycles carrying 10,20,30, output_selector=3'b111, conf_done=1 two cycles later, busy=0.
- Gapped stream: same run with src_valid low 2 cycles between words -> sel=SEL_IDLE during gaps, still exactly 3 delivery cycles, conf_done=1.
- Chain: header id=2, mask=3'b001, word 5 (last=0), then header id=6, mask=3'b011, words 7,8 (last=1) -> id 2 receives 5, id 6 receives 7,8, conf_done=1 only after id 6 acks.
- Bad headers: mask=3'b101 -> conf_error=1, err_code=1, no sel activity. Separately, conf_ack_bus[6]=1 at header -> err_code=2.
- Timeout: target never acks -> conf_error=1, err_code=3 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; start issued while busy earlier in the run is ignored.
- Reset mid-LOAD after 1 of 3 words: assert reset -> all outputs at reset values the same cycle, sel=SEL_IDLE. Release reset, then start -> state HDR, busy=1.

Source files
------------

// File: rtl/gc_conf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gc_conf_sequencer
// Brief    : Delivers a packed configuration stream to GC sub-blocks one target
//            at a time over conf_bus/sel/output_selector; reports done/error.
// Revision : 1.0
// ============================================================================
module gc_conf_sequencer #(
    parameter int DIMENSION                = 3,
    parameter int SELECT_WIDTH             = 3,
    parameter int ITERATION_VARIABLE_WIDTH = 16,
    parameter int ACK_TIMEOUT              = 15
) (
    input  logic                                conf_clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                src_valid,
    input  logic [ITERATION_VARIABLE_WIDTH-1:0] src_data,
    output logic                                src_ready,
    input  logic [2**SELECT_WIDTH-1:0]          conf_ack_bus,
    output logic [ITERATION_VARIABLE_WIDTH-1:0] conf_bus,
    output logic [SELECT_WIDTH-1:0]             sel,
    output logic [DIMENSION-1:0]                output_selector,
    output logic                                busy,
    output logic                                conf_done,
    output logic                                conf_error,
    output logic [1:0]                          err_code
);

    localparam int                     c_cnt_w    = $clog2(DIMENSION + 1);
    localparam int                     c_tmr_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SELECT_WIDTH-1:0] c_sel_idle = '1;
    localparam logic [c_tmr_w-1:0]     c_tmr_last = c_tmr_w'(ACK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_err_header  = 2'd1;
    localparam logic [1:0] c_err_acked   = 2'd2;
    localparam logic [1:0] c_err_timeout = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_LOAD     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t                    r_state;
    logic [SELECT_WIDTH-1:0]   r_target;
    logic [DIMENSION-1:0]      r_mask;
    logic                      r_last;
    logic [c_cnt_w-1:0]        r_remaining;
    logic [c_tmr_w-1:0]        r_timer;

    logic                      w_accept;
    logic [SELECT_WIDTH-1:0]   w_hdr_target;
    logic [DIMENSION-1:0]      w_hdr_mask;
    logic [DIMENSION-1:0]      w_mask_plus1;
    logic                      w_hdr_last;
    logic                      w_hdr_bad;
    logic                      w_hdr_acked;
    logic                      w_target_ack;
    logic [c_cnt_w-1:0]        w_popcount;

    assign w_accept     = src_valid & src_ready;
    assign w_hdr_target = src_data[SELECT_WIDTH-1:0];
    assign w_hdr_mask   = src_data[SELECT_WIDTH+DIMENSION-1:SELECT_WIDTH];
    assign w_hdr_last   = src_data[ITERATION_VARIABLE_WIDTH-1];
    assign w_mask_plus1 = w_hdr_mask + 1'b1;

    // A thermometer mask 0..01..1 has no bit shared with its own increment.
    assign w_hdr_bad    = (w_hdr_target == c_sel_idle) || (w_hdr_mask == '0) ||
                          ((w_hdr_mask & w_mask_plus1) != '0);
    assign w_hdr_acked  = conf_ack_bus[w_hdr_target];
    assign w_target_ack = conf_ack_bus[r_target];

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            w_popcount = w_popcount + c_cnt_w'(w_hdr_mask[i]);
        end
    end

    always_ff @(posedge conf_clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_target        <= '0;
            r_mask          <= '0;
            r_last          <= 1'b0;
            r_remaining     <= '0;
            r_timer         <= '0;
            src_ready       <= 1'b0;
            conf_bus        <= '0;
            sel             <= c_sel_idle;
            output_selector <= '0;
            busy            <= 1'b0;
            conf_done       <= 1'b0;
            conf_error      <= 1'b0;
            err_code        <= 2'd0;
        end else begin
            // The bus is idle unless a payload beat was accepted last cycle.
            sel             <= c_sel_idle;
            output_selector <= '0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        busy       <= 1'b1;
                        src_ready  <= 1'b1;
                        conf_done  <= 1'b0;
                        conf_error <= 1'b0;
                        err_code   <= 2'd0;
                    end
                end

                S_HDR: begin
                    if (w_accept) begin
                        if (w_hdr_bad) begin
                            r_state    <= S_ERR;
                            src_ready  <= 1'b0;
                            busy       <= 1'b0;
                            conf_error <= 1'b1;
                            err_code   <= c_err_header;
                        end else if (w_hdr_acked) begin
                            r_state    <= S_ERR;
                            src_ready  <= 1'b0;
                            busy       <= 1'b0;
                            conf_error <= 1'b1;
                            err_code   <= c_err_acked;
                        end else begin
                            r_state     <= S_LOAD;
                            r_target    <= w_hdr_target;
                            r_mask      <= w_hdr_mask;
                            r_last      <= w_hdr_last;
                            r_remaining <= w_popcount;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        conf_bus        <= src_data;
                        sel             <= r_target;
                        output_selector <= r_mask;
                        r_remaining     <= r_remaining - 1'b1;
                        if (r_remaining == c_cnt_one) begin
                            r_state   <= S_WAIT_ACK;
                            src_ready <= 1'b0;
                            r_timer   <= '0;
                        end
                    end
                end

                S_WAIT_ACK: begin
                    // First cycle carries the final word, so ack is ignored there.
                    if ((r_timer != '0) && w_target_ack) begin
                        if (r_last) begin
                            r_state   <= S_DONE;
                            busy      <= 1'b0;
                            conf_done <= 1'b1;
                        end else begin
                            r_state   <= S_HDR;
                            src_ready <= 1'b1;
                        end
                    end else if (r_timer == c_tmr_last) begin
                        r_state    <= S_ERR;
                        busy       <= 1'b0;
                        conf_error <= 1'b1;
                        err_code   <= c_err_timeout;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
